// File: rtl/prog_loader.sv
// prog_loader: boot-time program memory writer.
// Consumes a framed byte stream (16-bit LE word count, 4*N data bytes,
// XOR checksum byte) and writes little-endian 32-bit words to program
// memory starting at BASE_ADDR. busy keeps the CPU held during a load.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM} state_t;

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  xor_q, xor_d;
  logic [15:0] words_q, words_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        take;
  logic [15:0] n_full;

  // byte_ready is a pure state decode so the source sees no comb path back
  assign byte_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign take       = byte_valid & byte_ready;
  assign n_full     = {byte_data, n_q[7:0]};

  // Memory write port; address/data forced to zero outside WRITE
  assign mem_we        = (state_q == S_WRITE);
  assign mem_addr      = mem_we ? (BASE_ADDR + {14'd0, words_q, 2'b00}) : 32'd0;
  assign mem_wdata     = mem_we ? word_q : 32'd0;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = words_q;

  // Next-state and datapath updates for the load sequence
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    word_d  = word_q;
    xor_d   = xor_q;
    words_d = words_q;
    done_d  = done_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          words_d = 16'd0;
          xor_d   = 8'd0;
          idx_d   = 2'd0;
          n_d     = 16'd0;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (take) begin
          if (idx_q == 2'd0) begin
            n_d   = {8'd0, byte_data};
            idx_d = 2'd1;
          end else begin
            n_d   = n_full;
            idx_d = 2'd0;
            if ((n_full == 16'd0) || (int'(n_full) > MAX_WORDS)) begin
              error_d = 1'b1;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (take) begin
          word_d[{idx_q, 3'b000} +: 8] = byte_data;
          xor_d = xor_q ^ byte_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          words_d = words_q + 16'd1;
          state_d = ((words_q + 16'd1) == n_q) ? S_CSUM : S_DATA;
        end
      end
      S_CSUM: begin
        if (take) begin
          error_d = (byte_data != xor_q);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= 16'd0;
      idx_q   <= 2'd0;
      word_q  <= 32'd0;
      xor_q   <= 8'd0;
      words_q <= 16'd0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      xor_q   <= xor_d;
      words_q <= words_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: hand-computed frames and expected writes.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b1;
  logic        busy, done, error;
  logic [15:0] words_written;

  int checks = 0;
  int errors = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          we_cycles = 0;
  logic [7:0]  stim[$];

  prog_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Log every committed write and every cycle with mem_we high
  always @(posedge clk) begin
    if (mem_we) we_cycles <= we_cycles + 1;
    if (mem_we && mem_ready) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    we_cycles = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one byte and hold it until the loader accepts it
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) chk("send_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_stim();
    foreach (stim[i]) send_byte(stim[i]);
  endtask

  task automatic load_case1(input logic [7:0] csum);
    stim = '{8'h02, 8'h00, 8'h00, 8'haa, 8'h01, 8'h34,
             8'haa, 8'h55, 8'h02, 8'h34, csum};
  endtask

  task automatic check_case1(input string tag, input logic exp_err);
    chk({tag, "_done"},  32'(done), 32'd1);
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_words"}, 32'(words_written), 32'd2);
    chk({tag, "_ncommit"}, 32'(wa.size()), 32'd2);
    chk({tag, "_a0"}, (wa.size() > 0) ? wa[0] : 32'hxxxx_xxxx, 32'h0000_0000);
    chk({tag, "_d0"}, (wd.size() > 0) ? wd[0] : 32'hxxxx_xxxx, 32'h3401_aa00);
    chk({tag, "_a1"}, (wa.size() > 1) ? wa[1] : 32'hxxxx_xxxx, 32'h0000_0004);
    chk({tag, "_d1"}, (wd.size() > 1) ? wd[1] : 32'hxxxx_xxxx, 32'h3402_55aa);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_we"},    32'(mem_we), 32'd0);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_addr"},  mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_words"}, 32'(words_written), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check_zero_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: good two-word load, checksum 0x56
    clear_log();
    pulse_start();
    chk("c1_busy_start", 32'(busy), 32'd1);
    chk("c1_ready_len", 32'(byte_ready), 32'd1);
    load_case1(8'h56);
    send_stim();
    check_case1("c1", 1'b0);

    // 2: same data, bad checksum
    clear_log();
    pulse_start();
    chk("c2_done_cleared", 32'(done), 32'd0);
    load_case1(8'h57);
    send_stim();
    check_case1("c2", 1'b1);

    // 3a: N = 0
    clear_log();
    pulse_start();
    stim = '{8'h00, 8'h00};
    send_stim();
    chk("c3a_done",  32'(done), 32'd1);
    chk("c3a_error", 32'(error), 32'd1);
    chk("c3a_ready", 32'(byte_ready), 32'd0);
    chk("c3a_busy",  32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("c3a_nowe", 32'(we_cycles), 32'd0);

    // 3b: N = 2049
    clear_log();
    pulse_start();
    stim = '{8'h01, 8'h08};
    send_stim();
    chk("c3b_done",  32'(done), 32'd1);
    chk("c3b_error", 32'(error), 32'd1);
    chk("c3b_ready", 32'(byte_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("c3b_nowe", 32'(we_cycles), 32'd0);

    // 4: memory backpressure on the only write (N=1, csum 0x44)
    clear_log();
    mem_ready = 1'b0;
    pulse_start();
    stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_stim();
    byte_valid = 1'b1;
    byte_data  = 8'h44;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("c4_we_%0d", c),    32'(mem_we), 32'd1);
      chk($sformatf("c4_addr_%0d", c),  mem_addr, 32'h0000_0000);
      chk($sformatf("c4_wdata_%0d", c), mem_wdata, 32'h4433_2211);
      chk($sformatf("c4_ready_%0d", c), 32'(byte_ready), 32'd0);
      if (c == 3) mem_ready = 1'b1;
      @(posedge clk); #1;
    end
    begin
      int t = 0;
      while (busy && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      chk("c4_finish_timeout", 32'(t < 20), 32'd1);
    end
    byte_valid = 1'b0;
    chk("c4_wecycles", 32'(we_cycles), 32'd4);
    chk("c4_ncommit",  32'(wa.size()), 32'd1);
    chk("c4_done",     32'(done), 32'd1);
    chk("c4_error",    32'(error), 32'd0);
    chk("c4_words",    32'(words_written), 32'd1);

    // 5: async reset mid-word, then a clean reload
    clear_log();
    pulse_start();
    stim = '{8'h02, 8'h00, 8'h00, 8'haa};
    send_stim();
    chk("c5_words_pre", 32'(words_written), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("c5_rst");
    chk("c5_ncommit", 32'(wa.size()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    load_case1(8'h56);
    send_stim();
    check_case1("c5", 1'b0);

    // 6: bytes ignored in IDLE, start ignored while busy
    clear_log();
    byte_valid = 1'b1;
    byte_data  = 8'h99;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("c6_idle_ready", 32'(byte_ready), 32'd0);
    chk("c6_idle_busy",  32'(busy), 32'd0);
    chk("c6_idle_done",  32'(done), 32'd1);
    chk("c6_idle_error", 32'(error), 32'd0);
    byte_valid = 1'b0;
    pulse_start();
    stim = '{8'h02, 8'h00, 8'h00};
    send_stim();
    pulse_start();
    chk("c6_busy_hold", 32'(busy), 32'd1);
    stim = '{8'haa, 8'h01, 8'h34, 8'haa, 8'h55, 8'h02, 8'h34, 8'h56};
    send_stim();
    check_case1("c6", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time writer for the program memory.
- Consumes a framed byte stream and assembles little-endian 32-bit instruction words.
- Writes each word into program memory at a word-aligned byte address. Memory uses address[31:2] as the word index.
- Sits between the host byte link (UART receiver) and the program memory write port. Keeps the CPU held while busy.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written (must be 4-aligned)
MAX_WORDS, 2048, largest accepted word count N

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
start  input  1  one-cycle pulse that begins a load; ignored while busy
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle (transfer = byte_valid & byte_ready)
mem_we  output  1  write request to program memory
mem_addr  output  32  byte address of write, bits[1:0]=0
mem_wdata  output  32  word to write
mem_ready  input  1  memory accepts write this cycle (commit = mem_we & mem_ready)
busy  output  1  load in progress; CPU held in reset while high
done  output  1  sticky: last load finished (good or bad)
error  output  1  sticky: last load failed (bad length or checksum)
words_written  output  16  number of words committed in current/last load

Behaviour:
- Frame format: N[7:0], N[15:8], then 4*N data bytes, each word little-endian (first byte -> wdata[7:0]), then one checksum byte.
- Checksum = XOR of all 4*N data bytes. Length bytes are excluded.
- Reset (rst_n=0, async): state IDLE. All outputs 0, including mem_addr, mem_wdata, words_written. Shift register, counters and XOR accumulator cleared. A partially assembled word is discarded and never written.
- byte_ready is a decode of state only: 1 in LEN, DATA, CSUM; 0 in IDLE and WRITE. No combinational path from byte_valid to byte_ready.
- IDLE:
  - On start: clear done, error, words_written, XOR, byte index; busy=1; go to LEN.
  - byte_valid is ignored.
- LEN: accept 2 bytes into N. After the 2nd byte:
  - If N==0 or N>MAX_WORDS: error=1, done=1, busy=0, go to IDLE (no writes).
  - Else go to DATA.
- DATA:
  - Each accepted byte is shifted into the word register at lane [byte_idx] and XORed into the accumulator.
  - On the 4th byte: go to WRITE.
- WRITE:
  - mem_we=1 starting the cycle after the 4th byte is accepted.
  - mem_addr = BASE_ADDR + 4*words_written; mem_wdata = assembled word.
  - mem_we, mem_addr and mem_wdata are held stable until mem_ready.
  - On commit: words_written+1, mem_we=0 next cycle. If words_written+1==N go to CSUM, else go to DATA.
- CSUM: accept 1 byte.
  - Mismatch with the accumulator: error=1.
  - Then done=1, busy=0, go to IDLE.
- done and error hold until the next start. start while busy=1 has no effect.
- Address arithmetic is 32-bit modulo. N is 16-bit unsigned.
- Throughput with mem_ready tied high: one word per 5 cycles minimum (4 byte cycles + 1 write cycle).
- Simultaneous byte_valid and mem_ready in WRITE: the byte is not accepted (byte_ready=0) and must be held by the source.
- Writes already committed before a checksum failure remain in memory; error tells the system not to release the CPU.

Test Plan:
1. start; stream 02 00, 00 aa 01 34, aa 55 02 34, 56 (mem_ready=1) -> writes 0x3401aa00 @0x0 and 0x340255aa @0x4; words_written=2, done=1, error=0, busy=0.
2. Same stream with checksum 0x57 -> both writes occur; done=1, error=1.
3. Length 00 00 -> error=1, done=1, no mem_we. Length 01 08 (N=2049) -> same. byte_ready=0 after the 2nd length byte.
4. mem_ready held 0 for 3 cycles during the first WRITE -> mem_we=1 for 4 cycles with mem_addr/mem_wdata constant, byte_ready=0, byte_valid held by source not consumed. Exactly one commit.
5. rst_n pulsed low after 2 data bytes of word 0 -> all outputs 0 immediately, no write. A new start with case-1 stream gives the case-1 result.
6. start pulsed in DATA, and byte_valid=1 while IDLE -> no state change, no byte consumed, done/error unchanged.
